// File: rtl/msdf_online_multiplier.sv
// -----------------------------------------------------------------------------
// msdf_online_multiplier
//
// Radix-2 most-significant-digit-first online serial-serial multiplier.
// One signed digit of X and one of Y enter per cycle, MSD first. The product
// Z = X*Y leaves one signed digit per cycle after an online delay of 3.
//
// Digit encoding: +1 = 2'b01, 0 = 2'b00, -1 = 2'b11. An input of 2'b10 is
// read as 0. The outputs never drive 2'b10.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset; the unit runs while rst = 1
//   xj_plus_5  current X digit (ignored after the N-th digit)
//   yj_plus_5  current Y digit (ignored after the N-th digit)
//   Zj         current product digit (registered)
//   ready_Zj   product-digit valid strobe (registered)
//
// Handshake: ready_Zj is a valid-only strobe. It is high for exactly N
// consecutive cycles, and Zj holds digit z_i during those cycles. The
// consumer cannot apply backpressure. When ready_Zj is low, Zj is 2'b00.
//
// Sequencing: cnt counts the rising edges seen since reset. Edge k runs
// iteration j = k-3. The FSM phase is kept in `state`, a named enum register
// that checkers can bind to: IDLE (reset), INIT (k=0..2), OUTPUT (k=3..N+2),
// DONE (frozen until the next reset).
//
// Arithmetic: X, Y, W and v are exact two's-complement fixed-point values
// with N+3 fractional bits and 3 integer/sign bits.
// -----------------------------------------------------------------------------
module msdf_online_multiplier #(
    parameter int N = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] xj_plus_5,
    input  logic [1:0] yj_plus_5,
    output logic [1:0] Zj,
    output logic       ready_Zj
);

    localparam int F  = N + 3;          // fractional bits
    localparam int WD = N + 6;          // total datapath width
    localparam int CW = $clog2(N + 4);  // edge counter width, saturates at N+3

    localparam logic signed [WD-1:0] ONE  = WD'(1) << F;
    localparam logic signed [WD-1:0] HALF = WD'(1) << (F - 1);

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        OUTPUT,
        DONE
    } state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic signed [WD-1:0]   x_acc;
    logic signed [WD-1:0]   y_acc;
    logic signed [WD-1:0]   w_res;

    // Canonical digit code: any encoding other than 01 or 11 means zero.
    function automatic logic [1:0] canon(input logic [1:0] d);
        case (d)
            2'b01:   return 2'b01;
            2'b11:   return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    // Multiply a fixed-point value by a digit in {-1, 0, +1}.
    function automatic logic signed [WD-1:0] mul_digit(
        input logic signed [WD-1:0] a,
        input logic [1:0]           d
    );
        case (d)
            2'b01:   return a;
            2'b11:   return -a;
            default: return '0;
        endcase
    endfunction

    logic                 in_active;
    logic [1:0]           x_d;
    logic [1:0]           y_d;
    logic signed [WD-1:0] w_bit;
    logic signed [WD-1:0] y_next;
    logic signed [WD-1:0] x_next;
    logic signed [WD-1:0] prod;
    logic signed [WD-1:0] v;
    logic [1:0]           z_sel;
    logic signed [WD-1:0] w_sel;

    always_comb begin
        in_active = (int'(cnt) < N);
        x_d       = 2'b00;
        y_d       = 2'b00;
        w_bit     = '0;
        if (in_active) begin
            x_d = canon(xj_plus_5);
            y_d = canon(yj_plus_5);
            // The digit sampled on edge k has index k+1, so its weight is 2^-(k+1).
            w_bit = WD'(1) << (F - 1 - int'(cnt));
        end

        y_next = y_acc + mul_digit(w_bit, y_d);
        x_next = x_acc + mul_digit(w_bit, x_d);
        // X and Y hold at most N fractional digits, so the 2^-3 scaling is exact.
        prod   = mul_digit(x_acc, y_d) + mul_digit(y_next, x_d);
        v      = (w_res <<< 1) + (prod >>> 3);

        z_sel = 2'b00;
        if (v >= HALF) begin
            z_sel = 2'b01;
        end else if (v < -HALF) begin
            z_sel = 2'b11;
        end

        case (z_sel)
            2'b01:   w_sel = v - ONE;
            2'b11:   w_sel = v + ONE;
            default: w_sel = v;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            x_acc    <= '0;
            y_acc    <= '0;
            w_res    <= '0;
            Zj       <= 2'b00;
            ready_Zj <= 1'b0;
        end else begin
            case (state)
                IDLE, INIT, OUTPUT: begin
                    if (int'(cnt) == N + 3) begin
                        // The last digit has been shown for one cycle. Freeze here.
                        state    <= DONE;
                        Zj       <= 2'b00;
                        ready_Zj <= 1'b0;
                    end else begin
                        cnt   <= cnt + CW'(1);
                        x_acc <= x_next;
                        y_acc <= y_next;
                        if (int'(cnt) >= 3) begin
                            state    <= OUTPUT;
                            w_res    <= w_sel;
                            Zj       <= z_sel;
                            ready_Zj <= 1'b1;
                        end else begin
                            state    <= INIT;
                            w_res    <= v;
                            Zj       <= 2'b00;
                            ready_Zj <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= DONE;
                    Zj       <= 2'b00;
                    ready_Zj <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_msdf_online_multiplier.sv
// -----------------------------------------------------------------------------
// tb_msdf_online_multiplier
//
// Self-checking bench for msdf_online_multiplier. A reference model of the
// online recurrence computes the expected digits. They are pushed to exp_q
// when a run starts and popped on every cycle where ready_Zj is high.
// Inputs change on the falling edge and outputs are sampled on the falling
// edge.
// -----------------------------------------------------------------------------
module tb_msdf_online_multiplier;

    localparam int N = 8;

    typedef int dig_t [N];

    logic       clk;
    logic       rst;
    logic [1:0] xj_plus_5;
    logic [1:0] yj_plus_5;
    logic [1:0] Zj;
    logic       ready_Zj;

    int errors = 0;
    int checks = 0;

    logic [1:0] exp_q[$];

    msdf_online_multiplier #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .xj_plus_5 (xj_plus_5),
        .yj_plus_5 (yj_plus_5),
        .Zj        (Zj),
        .ready_Zj  (ready_Zj)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Integer fixed point scaled by 2^(N+3). Every step of the recurrence is
    // exact at this scale.
    function automatic void model(input dig_t xd, input dig_t yd, output dig_t zd);
        int sc;
        int wv;
        int xa;
        int ya;
        int vv;
        int xi;
        int yi;
        int z;
        int wt;
        sc = 1 << (N + 3);
        wv = 0;
        xa = 0;
        ya = 0;
        for (int k = 0; k <= N + 2; k++) begin
            xi = (k < N) ? xd[k] : 0;
            yi = (k < N) ? yd[k] : 0;
            wt = sc >> (k + 1);
            ya = ya + yi * wt;
            vv = 2 * wv + (xa * yi + ya * xi) / 8;
            xa = xa + xi * wt;
            if (k >= 3) begin
                if (2 * vv >= sc) begin
                    z = 1;
                end else if (2 * vv < -sc) begin
                    z = -1;
                end else begin
                    z = 0;
                end
                wv = vv - z * sc;
                zd[k - 3] = z;
            end else begin
                wv = vv;
            end
        end
    endfunction

    function automatic logic [1:0] enc_out(input int d);
        if (d == 1) return 2'b01;
        if (d == -1) return 2'b11;
        return 2'b00;
    endfunction

    // A zero input digit is sent as 00 or as the alias 10 at random.
    function automatic logic [1:0] enc_in(input int d);
        if (d == 1) return 2'b01;
        if (d == -1) return 2'b11;
        return ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            xj_plus_5 = 2'($urandom_range(0, 3));
            yj_plus_5 = 2'($urandom_range(0, 3));
            @(posedge clk);
        end
        @(negedge clk);
        check("reset_ready", 32'(ready_Zj), 32'd0);
        check("reset_zj", 32'(Zj), 32'd0);
        rst = 1'b1;
    endtask

    // Runs one product from reset release. The run covers N+3+extra edges.
    // If abort_at >= 0, reset is asserted mid-cycle after edge abort_at.
    task automatic run_vec(input string name, input dig_t xd, input dig_t yd,
                           input int extra, input int abort_at);
        dig_t       zd;
        logic [1:0] exp_z;
        int         z_int;
        int         x_int;
        int         y_int;
        int         diff;
        model(xd, yd, zd);
        exp_q.delete();
        for (int i = 0; i < N; i++) exp_q.push_back(enc_out(zd[i]));
        z_int = 0;
        x_int = 0;
        y_int = 0;
        for (int i = 0; i < N; i++) begin
            x_int += xd[i] * (1 << (N - 1 - i));
            y_int += yd[i] * (1 << (N - 1 - i));
        end
        for (int k = 0; k <= N + 2 + extra; k++) begin
            if (k < N) begin
                xj_plus_5 = enc_in(xd[k]);
                yj_plus_5 = enc_in(yd[k]);
            end else begin
                xj_plus_5 = 2'($urandom_range(0, 3));
                yj_plus_5 = 2'($urandom_range(0, 3));
            end
            @(posedge clk);
            @(negedge clk);
            check({name, "_ready"}, 32'(ready_Zj), 32'((k >= 3 && k <= N + 2) ? 1 : 0));
            if (ready_Zj) begin
                if (exp_q.size() == 0) begin
                    check({name, "_exp_q_underrun"}, 32'(exp_q.size()), 32'd1);
                end else begin
                    exp_z = exp_q.pop_front();
                    check({name, "_zj"}, 32'(Zj), 32'(exp_z));
                end
                if (Zj == 2'b01) z_int += 1 << (N + 2 - k);
                if (Zj == 2'b11) z_int -= 1 << (N + 2 - k);
            end else begin
                check({name, "_zj_idle"}, 32'(Zj), 32'd0);
            end
            if (k == abort_at) begin
                #2;
                rst = 1'b0;
                #1;
                check({name, "_abort_ready"}, 32'(ready_Zj), 32'd0);
                check({name, "_abort_zj"}, 32'(Zj), 32'd0);
                exp_q.delete();
                return;
            end
        end
        check({name, "_all_digits"}, 32'(exp_q.size()), 32'd0);
        // The product must match X*Y to within one unit of 2^-N.
        diff = z_int * (1 << N) - x_int * y_int;
        if (diff < 0) diff = -diff;
        check({name, "_accuracy"}, 32'(diff < (1 << N)), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        dig_t zx;
        dig_t hx;
        dig_t hy;
        dig_t mx;
        dig_t my;
        dig_t nx;
        dig_t rx;
        dig_t ry;
        rst = 1'b0;
        xj_plus_5 = 2'b00;
        yj_plus_5 = 2'b00;

        zx = '{0, 0, 0, 0, 0, 0, 0, 0};
        hx = '{1, 0, 0, 0, 0, 0, 0, 0};
        hy = '{1, 0, 0, 0, 0, 0, 0, 0};
        mx = '{1, 1, -1, 0, 1, -1, 0, 1};
        my = '{1, 0, 1, -1, -1, 1, 1, 0};
        nx = '{-1, -1, -1, -1, -1, -1, -1, -1};

        // A fixed vector taken directly from the recurrence, independent of the model.
        do_reset();
        begin
            int seen;
            seen = 0;
            for (int k = 0; k <= N + 2; k++) begin
                xj_plus_5 = (k == 0) ? 2'b01 : 2'b00;
                yj_plus_5 = (k == 0) ? 2'b01 : 2'b00;
                @(posedge clk);
                @(negedge clk);
                if (k == 3) check("half_z1", 32'(Zj), 32'h1);
                if (k == 4) check("half_z2", 32'(Zj), 32'h3);
                if (k == 5) check("half_z3", 32'(Zj), 32'h0);
                if (ready_Zj) seen++;
            end
            check("half_ready_count", 32'(seen), 32'(N));
        end

        do_reset();
        run_vec("zero", zx, zx, 2, -1);
        do_reset();
        run_vec("half", hx, hy, 1, -1);
        do_reset();
        run_vec("main", mx, my, 2, -1);
        do_reset();
        run_vec("neg", nx, nx, 1, -1);
        do_reset();
        run_vec("mixsign", mx, nx, 1, -1);

        // Abort mid-run, then rerun and keep going well past completion.
        do_reset();
        run_vec("abort", mx, my, 2, 5);
        do_reset();
        run_vec("rerun", mx, my, 10, -1);

        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < N; i++) begin
                rx[i] = $urandom_range(0, 2) - 1;
                ry[i] = $urandom_range(0, 2) - 1;
            end
            do_reset();
            run_vec("rand", rx, ry, 1, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
